// File: rtl/dff_pipe.sv
// dff_pipe: valid/ready register pipeline with bubble collapsing, synchronous flush and occupancy count.
// Define DFF_PIPE_DATA_RST_EN to give the data registers an asynchronous reset to RST_VAL.
module dff_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [WIDTH-1:0]           data_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);
    localparam int CW = $clog2(DEPTH+1);
    logic [DEPTH-1:0] v_q, v_d, adv, ld;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
    logic [CW-1:0]    occ_q, occ_d;
    logic             xfer_in, xfer_out;

    always_comb begin
        adv = '0;
        adv[DEPTH-1] = v_q[DEPTH-1] & ready_i;
        for (int k = DEPTH-2; k >= 0; k--) adv[k] = v_q[k] & (!v_q[k+1] | adv[k+1]);
        ld = ~v_q | adv;
        ready_o = ld[0];
        xfer_in = valid_i & ready_o;
        xfer_out = adv[DEPTH-1];
        // flush clears valids but leaves data untouched
        v_d[0] = flush_i ? 1'b0 : (ld[0] ? valid_i : v_q[0]);
        d_d[0] = (ld[0] & valid_i & !flush_i) ? data_i : d_q[0];
        for (int k = 1; k < DEPTH; k++) begin
            v_d[k] = flush_i ? 1'b0 : (ld[k] ? v_q[k-1] : v_q[k]);
            d_d[k] = (ld[k] & v_q[k-1] & !flush_i) ? d_q[k-1] : d_q[k];
        end
        occ_d = flush_i ? '0 : occ_q + CW'(xfer_in) - CW'(xfer_out);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_q   <= '0;
            occ_q <= '0;
        end else begin
            v_q   <= v_d;
            occ_q <= occ_d;
        end
    end

`ifdef DFF_PIPE_DATA_RST_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++) d_q[k] <= RST_VAL;
        end else begin
            d_q <= d_d;
        end
    end
`else
    logic unused_rst_val;
    assign unused_rst_val = ^RST_VAL;
    always_ff @(posedge clk) begin
        d_q <= d_d;
    end
`endif

    assign valid_o     = v_q[DEPTH-1];
    assign data_o      = d_q[DEPTH-1];
    assign occupancy_o = occ_q;
endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: directed vector table on a DEPTH=3 pipe plus randomized traffic on DEPTH=1 and DEPTH=5
// pipes checked against a word-position reference model.
module tb_dff_pipe;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic       fl3, vi3, ri3, ro3, vo3;
    logic [7:0] di3, do3;
    logic [1:0] oc3;

    logic        fl0 = 1'b0;
    logic        vi_r [2];
    logic        ri_r [2];
    logic [7:0]  di_r [2];
    logic        ro_r [2];
    logic        vo_r [2];
    logic [7:0]  do_r [2];
    logic [31:0] oc_r [2];
    logic        ro1, vo1, ro5, vo5;
    logic [7:0]  do1, do5;
    logic [0:0]  oc1;
    logic [2:0]  oc5;

    dff_pipe #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'h3C)) u3 (
        .clk(clk), .reset_n(reset_n), .flush_i(fl3), .valid_i(vi3), .ready_o(ro3), .data_i(di3),
        .valid_o(vo3), .ready_i(ri3), .data_o(do3), .occupancy_o(oc3));
    dff_pipe #(.WIDTH(8), .DEPTH(1)) u1 (
        .clk(clk), .reset_n(reset_n), .flush_i(fl0), .valid_i(vi_r[0]), .ready_o(ro1), .data_i(di_r[0]),
        .valid_o(vo1), .ready_i(ri_r[0]), .data_o(do1), .occupancy_o(oc1));
    dff_pipe #(.WIDTH(8), .DEPTH(5)) u5 (
        .clk(clk), .reset_n(reset_n), .flush_i(fl0), .valid_i(vi_r[1]), .ready_o(ro5), .data_i(di_r[1]),
        .valid_o(vo5), .ready_i(ri_r[1]), .data_o(do5), .occupancy_o(oc5));

    assign ro_r[0] = ro1;
    assign vo_r[0] = vo1;
    assign do_r[0] = do1;
    assign oc_r[0] = {31'b0, oc1};
    assign ro_r[1] = ro5;
    assign vo_r[1] = vo5;
    assign do_r[1] = do5;
    assign oc_r[1] = {29'b0, oc5};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic fl; logic vi; logic [7:0] di; logic ri;
        logic er; logic ev; logic [7:0] ed; logic [1:0] eo;
    } vec_t;

    function automatic vec_t mk(int fl, int vi, int di, int ri, int er, int ev, int ed, int eo);
        vec_t t;
        t.fl = fl[0]; t.vi = vi[0]; t.di = di[7:0]; t.ri = ri[0];
        t.er = er[0]; t.ev = ev[0]; t.ed = ed[7:0]; t.eo = eo[1:0];
        return t;
    endfunction

    vec_t tbl[$];

    // word-level model: each queued word carries its stage position; the oldest word sits nearest the output
    int         dep [2] = '{1, 5};
    int         mpos [2][8];
    logic [7:0] mdat [2][8];
    int         mcnt [2] = '{0, 0};
    bit         ev, er, xo, xi;
    int         lim;

    initial begin
        fl3 = 0; vi3 = 0; ri3 = 0; di3 = 0;
        for (int j = 0; j < 2; j++) begin vi_r[j] = 0; ri_r[j] = 0; di_r[j] = 0; end
        repeat (2) @(negedge clk);
        chk("reset valid_o", {31'b0, vo3}, 0);
        chk("reset occupancy_o", {30'b0, oc3}, 0);
        chk("reset ready_o", {31'b0, ro3}, 1);
        chk("reset d1 valid_o", {31'b0, vo_r[0]}, 0);
        chk("reset d5 occupancy_o", oc_r[1], 0);
`ifdef DFF_PIPE_DATA_RST_EN
        chk("reset data_o", {24'b0, do3}, 32'h3C);
`endif
        reset_n = 1;

        // stream 01..05, ready_i=1
        tbl.push_back(mk(0,1,'h01,1, 1,0,'h00,0));
        tbl.push_back(mk(0,1,'h02,1, 1,0,'h00,1));
        tbl.push_back(mk(0,1,'h03,1, 1,0,'h00,2));
        tbl.push_back(mk(0,1,'h04,1, 1,1,'h01,3));
        tbl.push_back(mk(0,1,'h05,1, 1,1,'h02,3));
        tbl.push_back(mk(0,0,'h00,1, 1,1,'h03,3));
        tbl.push_back(mk(0,0,'h00,1, 1,1,'h04,2));
        tbl.push_back(mk(0,0,'h00,1, 1,1,'h05,1));
        tbl.push_back(mk(0,0,'h00,1, 1,0,'h00,0));
        // full stall then one release cycle
        tbl.push_back(mk(0,1,'hA0,0, 1,0,'h00,0));
        tbl.push_back(mk(0,1,'hA1,0, 1,0,'h00,1));
        tbl.push_back(mk(0,1,'hA2,0, 1,0,'h00,2));
        tbl.push_back(mk(0,1,'hA3,0, 0,1,'hA0,3));
        tbl.push_back(mk(0,1,'hA3,1, 1,1,'hA0,3));
        tbl.push_back(mk(0,0,'h00,0, 0,1,'hA1,3));
        tbl.push_back(mk(0,0,'h00,1, 1,1,'hA1,3));
        tbl.push_back(mk(0,0,'h00,1, 1,1,'hA2,2));
        tbl.push_back(mk(0,0,'h00,1, 1,1,'hA3,1));
        tbl.push_back(mk(0,0,'h00,1, 1,0,'h00,0));
        // flush with a dropped input word
        tbl.push_back(mk(0,1,'h11,0, 1,0,'h00,0));
        tbl.push_back(mk(0,1,'h22,0, 1,0,'h00,1));
        tbl.push_back(mk(1,1,'h55,0, 1,0,'h00,2));
        tbl.push_back(mk(0,0,'h00,1, 1,0,'h00,0));
        tbl.push_back(mk(0,0,'h00,1, 1,0,'h00,0));
        tbl.push_back(mk(0,0,'h00,1, 1,0,'h00,0));
        tbl.push_back(mk(0,0,'h00,1, 1,0,'h00,0));
        // flush on a full pipe while the output transfers
        tbl.push_back(mk(0,1,'h31,0, 1,0,'h00,0));
        tbl.push_back(mk(0,1,'h32,0, 1,0,'h00,1));
        tbl.push_back(mk(0,1,'h33,0, 1,0,'h00,2));
        tbl.push_back(mk(1,1,'h34,1, 1,1,'h31,3));
        tbl.push_back(mk(0,0,'h00,1, 1,0,'h00,0));
        tbl.push_back(mk(0,0,'h00,0, 1,0,'h00,0));

        foreach (tbl[i]) begin
            fl3 = tbl[i].fl; vi3 = tbl[i].vi; di3 = tbl[i].di; ri3 = tbl[i].ri;
            #1;
            chk($sformatf("vec%0d ready_o", i), {31'b0, ro3}, {31'b0, tbl[i].er});
            chk($sformatf("vec%0d valid_o", i), {31'b0, vo3}, {31'b0, tbl[i].ev});
            chk($sformatf("vec%0d occupancy_o", i), {30'b0, oc3}, {30'b0, tbl[i].eo});
            if (tbl[i].ev) chk($sformatf("vec%0d data_o", i), {24'b0, do3}, {24'b0, tbl[i].ed});
            @(posedge clk);
            @(negedge clk);
        end
        fl3 = 0;

        // asynchronous reset between edges on a full, stalled pipe
        vi3 = 1; ri3 = 0;
        for (int i = 0; i < 3; i++) begin
            di3 = 8'(8'h77 + i);
            @(posedge clk);
            @(negedge clk);
        end
        vi3 = 0;
        #1;
        chk("pre-reset valid_o", {31'b0, vo3}, 1);
        chk("pre-reset occupancy_o", {30'b0, oc3}, 3);
        @(posedge clk);
        #2 reset_n = 0;
        #1;
        chk("async reset valid_o", {31'b0, vo3}, 0);
        chk("async reset occupancy_o", {30'b0, oc3}, 0);
        chk("async reset ready_o", {31'b0, ro3}, 1);
`ifdef DFF_PIPE_DATA_RST_EN
        chk("async reset data_o", {24'b0, do3}, 32'h3C);
`endif
        @(negedge clk);
        reset_n = 1;
        #1;
        chk("post-reset valid_o", {31'b0, vo3}, 0);
        @(negedge clk);

        // random traffic with a drain tail
        for (int c = 0; c < 10020; c++) begin
            for (int j = 0; j < 2; j++) begin
                vi_r[j] = (c < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
                ri_r[j] = (c < 10000) ? 1'($urandom_range(0, 1)) : 1'b1;
                di_r[j] = 8'($urandom);
            end
            #1;
            for (int j = 0; j < 2; j++) begin
                ev = mcnt[j] > 0 && mpos[j][0] == dep[j] - 1;
                er = mcnt[j] < dep[j] || ri_r[j];
                chk($sformatf("rnd d%0d c%0d valid_o", dep[j], c), {31'b0, vo_r[j]}, {31'b0, ev});
                chk($sformatf("rnd d%0d c%0d ready_o", dep[j], c), {31'b0, ro_r[j]}, {31'b0, er});
                chk($sformatf("rnd d%0d c%0d occupancy_o", dep[j], c), oc_r[j], mcnt[j]);
                if (ev) chk($sformatf("rnd d%0d c%0d data_o", dep[j], c), {24'b0, do_r[j]}, {24'b0, mdat[j][0]});
                xo = ev && ri_r[j];
                xi = vi_r[j] && er;
                if (xo) begin
                    for (int i = 0; i < mcnt[j] - 1; i++) begin
                        mpos[j][i] = mpos[j][i+1];
                        mdat[j][i] = mdat[j][i+1];
                    end
                    mcnt[j]--;
                end
                lim = dep[j];
                for (int i = 0; i < mcnt[j]; i++) begin
                    mpos[j][i] = (mpos[j][i] + 1 < lim - 1) ? mpos[j][i] + 1 : lim - 1;
                    lim = mpos[j][i];
                end
                if (xi) begin
                    mpos[j][mcnt[j]] = 0;
                    mdat[j][mcnt[j]] = di_r[j];
                    mcnt[j]++;
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        chk("drain d1 occupancy_o", oc_r[0], 0);
        chk("drain d5 occupancy_o", oc_r[1], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dff_pipe.md
# dff_pipe

Parametrised register pipeline with per-stage valid bits and a valid/ready handshake, generalising the single-bit flop to WIDTH-bit data, DEPTH stages and backpressure. Stalls collapse bubbles: a stage advances whenever the next stage is empty or is itself advancing. It is the standard retiming and delay element between producer and consumer blocks, with a synchronous flush and an occupancy count for debug and credit logic.

## Interface
- WIDTH, 8: data width in bits, ≥1.
- DEPTH, 3: number of register stages, ≥1.
- RST_VAL, '0: data-register reset value. Used only when DFF_PIPE_DATA_RST_EN is defined.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous clear of all stages.
- valid_i  in  1  input data valid.
- ready_o  out  1  pipeline can accept this cycle.
- data_i  in  WIDTH  input data.
- valid_o  out  1  last stage holds valid data.
- ready_i  in  1  consumer accepts this cycle.
- data_o  out  WIDTH  last-stage data.
- occupancy_o  out  $clog2(DEPTH+1)  number of valid stages.

## Operation
- Stages are numbered 0 (input) to DEPTH-1 (output). Each stage holds a valid bit v[k] and a data register d[k].
- Advance rule:
  - adv[DEPTH-1] = v[DEPTH-1] & ready_i.
  - adv[k] = v[k] & (!v[k+1] | adv[k+1]).
  - A stage loads from its predecessor when the stage is empty or advancing.
- Input side:
  - ready_o = !v[0] | adv[0]. This is combinational from ready_i through the chain.
  - A transfer in occurs when valid_i & ready_o.
- Output side:
  - valid_o = v[DEPTH-1] and data_o = d[DEPTH-1], both directly from registers.
  - A transfer out occurs when valid_o & ready_i.
- Data registers update only on load. Non-loaded stages hold their value, so data never changes under a stalled valid.
- occupancy_o is a registered counter:
  - +1 on transfer in only, -1 on transfer out only, unchanged on both or neither.
  - It never exceeds DEPTH and never underflows.
- flush_i has priority over all other updates at the next edge:
  - All v[k] clear and occupancy_o becomes 0.
  - A transfer out in the flush cycle still completes, because the consumer sampled it.
  - A valid_i in the flush cycle is dropped even if ready_o=1.
  - Data registers keep their contents during flush.
- Reset (reset_n=0), asserted at any time including mid-transfer:
  - Immediately, asynchronously: all v[k]=0, valid_o=0, occupancy_o=0.
  - ready_o=1 after all v[k] clear.
  - Data registers behave as described under Configuration.
  - Deassertion is synchronised externally. The first accepting edge is the first rising clk with reset_n=1.

## Timing
- Latency: a word accepted at edge N appears on valid_o after edge N+DEPTH-1 when unstalled, i.e. DEPTH cycles accept-to-present.
- Throughput: 1 word/cycle while ready_i=1.
- Full stall: DEPTH words accepted with ready_i=0 gives ready_o=0 and occupancy_o=DEPTH. With full occupancy, ready_i=1 makes ready_o=1 in the same cycle.
- Bubbles: a gap of empty stages upstream of a stall collapses at one stage per cycle.
- ready_o has a combinational path from ready_i. valid_o, data_o and occupancy_o have no combinational input paths.

## Configuration
- DFF_PIPE_DATA_RST_EN defined: every d[k] resets asynchronously to RST_VAL with reset_n, so data_o=RST_VAL during and after reset.
- DFF_PIPE_DATA_RST_EN undefined: d[k] have no reset and are X until first load, for smaller area. Valid bits and the counter are always reset.
- Handshake and valid behaviour are identical in both builds.

## Test plan
- DEPTH=3, WIDTH=8, ready_i=1, stream 0x01..0x05 back-to-back -> valid_o first high 3 cycles after the first accept, data_o is 0x01..0x05 on consecutive cycles, occupancy_o stays ≤3.
- ready_i=0, push 4 words 0xA0..0xA3 -> 0xA0..0xA2 accepted, ready_o=0 on the 4th, occupancy_o=3. Then ready_i=1 for one cycle -> 0xA0 out, 0xA3 accepted the same cycle, occupancy_o stays 3.
- Fill 2 words, then flush_i=1 with valid_i=1 and data 0x55 -> next cycle occupancy_o=0, valid_o=0, and 0x55 never appears at the output.
- Assert reset_n=0 mid-stream between clock edges -> valid_o and occupancy_o go 0 without a clock edge. With DFF_PIPE_DATA_RST_EN and RST_VAL=0x3C, data_o=0x3C.
- Random valid_i/ready_i at 50% each, 10k cycles, DEPTH=1 and DEPTH=5 -> output order equals input order, no loss or duplication, occupancy_o equals accepted minus emitted, data stable while valid_o & !ready_i.
